// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions: {g,f,e,d,c,b,a} bit ordering, active-high glyphs 0-F.
// Any block that drives the board's segment bus should pull its patterns from here.
package seven_seg_pkg;

   localparam int SEG_W = 7;
   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;
   localparam logic [SEG_W-1:0] SEG_0   = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1   = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2   = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3   = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4   = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5   = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6   = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7   = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8   = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9   = 7'h6F;
   localparam logic [SEG_W-1:0] SEG_HA  = 7'h77;
   localparam logic [SEG_W-1:0] SEG_HB  = 7'h7C;
   localparam logic [SEG_W-1:0] SEG_HC  = 7'h39;
   localparam logic [SEG_W-1:0] SEG_HD  = 7'h5E;
   localparam logic [SEG_W-1:0] SEG_HE  = 7'h79;
   localparam logic [SEG_W-1:0] SEG_HF  = 7'h71;

   function automatic logic [SEG_W-1:0] hex_pattern(input logic [3:0] i_hex);
      logic [SEG_W-1:0] w_pat;
      w_pat = SEG_OFF;
      case (i_hex)
         4'h0: w_pat = SEG_0;
         4'h1: w_pat = SEG_1;
         4'h2: w_pat = SEG_2;
         4'h3: w_pat = SEG_3;
         4'h4: w_pat = SEG_4;
         4'h5: w_pat = SEG_5;
         4'h6: w_pat = SEG_6;
         4'h7: w_pat = SEG_7;
         4'h8: w_pat = SEG_8;
         4'h9: w_pat = SEG_9;
         4'hA: w_pat = SEG_HA;
         4'hB: w_pat = SEG_HB;
         4'hC: w_pat = SEG_HC;
         4'hD: w_pat = SEG_HD;
         4'hE: w_pat = SEG_HE;
         default: w_pat = SEG_HF;
      endcase
      return w_pat;
   endfunction

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational hex nibble to active-high {g..a} segment pattern.
module hex_to_seven_seg
   import seven_seg_pkg::*;
(
   input  logic [3:0]       i_hex,
   output logic [SEG_W-1:0] o_seg
);

   assign o_seg = hex_pattern(i_hex);

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed 7-segment driver: snapshots NUM_DIGITS nibbles once per frame and scans them
// one digit per REFRESH_DIV clocks onto a shared registered seg bus with one-hot anodes.
module seven_seg_scanner
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_enable,
   input  logic [4*NUM_DIGITS-1:0] i_digits_in,
   input  logic [NUM_DIGITS-1:0]   i_digit_en,
   output logic [SEG_W-1:0]        o_seg,
   output logic [NUM_DIGITS-1:0]   o_an,
   output logic                    o_frame_tick
);

   localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [SEG_W-1:0]      SEG_INV = ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
   localparam logic [NUM_DIGITS-1:0] AN_INV  = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   logic [DIV_W-1:0]            r_div_cnt;
   logic [IDX_W-1:0]            r_idx;
   logic [NUM_DIGITS-1:0][3:0]  r_shadow;
   logic [NUM_DIGITS-1:0]       r_shadow_en;
   logic                        r_load_pend;
   logic [SEG_W-1:0]            r_seg;
   logic [NUM_DIGITS-1:0]       r_an;
   logic                        r_frame_tick;

   logic                        w_div_last;
   logic                        w_idx_last;
   logic                        w_snap;
   logic                        w_lit;
   logic [SEG_W-1:0]            w_seg_pat;
   logic [SEG_W-1:0]            w_seg_hi;
   logic [NUM_DIGITS-1:0]       w_an_hi;

   assign w_div_last = (r_div_cnt == DIV_W'(REFRESH_DIV - 1));
   assign w_idx_last = (r_idx == IDX_W'(NUM_DIGITS - 1));
   // A disabled cycle blocks both the wrap and the pending first load.
   assign w_snap     = i_enable && (r_load_pend || (w_div_last && w_idx_last));
   assign w_lit      = i_enable && r_shadow_en[r_idx];

   hex_to_seven_seg u_dec (
      .i_hex (r_shadow[r_idx]),
      .o_seg (w_seg_pat)
   );

   assign w_seg_hi = w_lit ? w_seg_pat : SEG_OFF;
   assign w_an_hi  = w_lit ? (NUM_DIGITS'(1) << r_idx) : '0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div_cnt    <= '0;
         r_idx        <= '0;
         r_shadow     <= '0;
         r_shadow_en  <= '0;
         r_load_pend  <= 1'b1;
         r_seg        <= SEG_OFF ^ SEG_INV;
         r_an         <= AN_INV;
         r_frame_tick <= 1'b0;
      end else begin
         if (i_enable) begin
            if (w_div_last) begin
               r_div_cnt <= '0;
               r_idx     <= w_idx_last ? '0 : r_idx + 1'b1;
            end else begin
               r_div_cnt <= r_div_cnt + 1'b1;
            end
         end
         if (w_snap) begin
            r_shadow    <= i_digits_in;
            r_shadow_en <= i_digit_en;
            r_load_pend <= 1'b0;
         end
         // Tick marks the first cycle the fresh snapshot is held in the shadow.
         r_frame_tick <= w_snap;
         r_seg        <= w_seg_hi ^ SEG_INV;
         r_an         <= w_an_hi ^ AN_INV;
      end
   end

   assign o_seg        = r_seg;
   assign o_an         = r_an;
   assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench: a frame-arithmetic model pushes expected outputs per clock; a monitor
// pops and compares on the falling edge. Active-low display, 4 digits, 4 clocks per digit.
module tb_seven_seg_scanner;

   localparam int ND = 4;
   localparam int RD = 4;
   localparam int FR = ND * RD;

   typedef struct {
      logic [6:0] seg;
      logic [3:0] an;
      logic       ft;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [15:0] digits;
   logic [3:0]  den;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        ft;

   int checks   = 0;
   int failures = 0;

   exp_t q[$];

   logic [6:0] dec_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   seven_seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(1'b1)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_enable     (enable),
      .i_digits_in  (digits),
      .i_digit_en   (den),
      .o_seg        (seg),
      .o_an         (an),
      .o_frame_tick (ft)
   );

   always #5 clk = ~clk;

   // Reference model: n_en counts enabled cycles since reset. The digit on show is
   // (n/RD)%ND; snapshots happen on the first enabled cycle and on every frame's last cycle.
   initial begin : model
      int         n_en;
      logic [3:0] m_dig [ND];
      logic [3:0] m_en;
      n_en = 0;
      m_en = '0;
      for (int k = 0; k < ND; k++) m_dig[k] = '0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            n_en = 0;
            m_en = '0;
            for (int k = 0; k < ND; k++) m_dig[k] = '0;
            q.delete();
         end else begin
            exp_t       e;
            int         idx;
            logic [3:0] one;
            e.seg = 7'h7F;
            e.an  = 4'hF;
            e.ft  = 1'b0;
            if (enable) begin
               idx = (n_en / RD) % ND;
               if (m_en[idx]) begin
                  one   = 4'b0001 << idx;
                  e.an  = ~one;
                  e.seg = ~dec_tbl[m_dig[idx]];
               end
               if (n_en == 0 || (n_en % FR) == FR - 1) begin
                  for (int k = 0; k < ND; k++) m_dig[k] = digits[4*k +: 4];
                  m_en = den;
                  e.ft = 1'b1;
               end
               n_en++;
            end
            q.push_back(e);
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         checks++;
         if ($countones(~an) > 1) begin
            failures++;
            $display("FAIL onehot an=%h", an);
         end
         if (!rst_n) begin
            checks++;
            if (seg !== 7'h7F || an !== 4'hF || ft !== 1'b0) begin
               failures++;
               $display("FAIL reset_dark got seg=%h an=%h ft=%b exp seg=7f an=f ft=0",
                        seg, an, ft);
            end
         end else if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (seg !== e.seg || an !== e.an || ft !== e.ft) begin
               failures++;
               $display("FAIL scan t=%0t got seg=%h an=%h ft=%b exp seg=%h an=%h ft=%b",
                        $time, seg, an, ft, e.seg, e.an, e.ft);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin : stim
      rst_n  = 1'b0;
      enable = 1'b0;
      digits = '0;
      den    = '0;
      repeat (5) begin
         @(posedge clk); #1;
         enable = 1'($urandom);
         digits = 16'($urandom);
         den    = 4'($urandom);
      end
      @(posedge clk); #1;
      rst_n  = 1'b1;
      enable = 1'b1;
      digits = 16'h1234;
      den    = 4'hF;
      cyc(22);
      digits = 16'hABCD;
      cyc(30);
      den = 4'b0101;
      cyc(36);
      den = 4'hF;
      cyc(7);

      // Asynchronous reset pulse between clock edges.
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (seg !== 7'h7F || an !== 4'hF || ft !== 1'b0) begin
         failures++;
         $display("FAIL async_rst got seg=%h an=%h ft=%b exp seg=7f an=f ft=0", seg, an, ft);
      end
      #1;
      rst_n  = 1'b1;
      digits = 16'h5E07;
      cyc(10);

      // Pause in the middle of digit 2, then resume.
      enable = 1'b0;
      cyc(10);
      enable = 1'b1;
      cyc(24);

      repeat (400) begin
         @(posedge clk); #1;
         enable = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 3) == 0) digits = 16'($urandom);
         if ($urandom_range(0, 5) == 0) den = 4'($urandom);
      end
      repeat (2) @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
